// File: rtl/div_sequencer.sv
// Sequencer and trial-subtract ALU for a 32-iteration restoring divider.
// It drives the load, shift-iterate and final shift-right strobes of the remainder register.
//
// state   | meaning
// S_IDLE  | waiting for Start
// S_LOAD  | remainder register loads {0, dividend}
// S_ITER  | one restoring iteration per cycle, WIDTH cycles
// S_SHIFT | final right shift of the upper half
// S_DONE  | result valid, new Start accepted
module div_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Divisor_in,
   input  logic [WIDTH-1:0] Remainder_hi,
   output logic             Load_ctrl,
   output logic             W_ctrl,
   output logic             SRL_ctrl,
   output logic [WIDTH-1:0] ALU_Result,
   output logic             ALU_Carry,
   output logic             Ready,
   output logic             Busy,
   output logic             DivZero,
   output logic [CNT_W-1:0] Count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ITER  = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic [WIDTH-1:0] divisor_reg;
   logic             accept;
   logic [WIDTH:0]   diff;

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state       <= S_IDLE;
         Count       <= '0;
         divisor_reg <= '0;
         DivZero     <= 1'b0;
      end else begin
         state <= state_nxt;
         Count <= count_nxt;
         if (accept) begin
            divisor_reg <= Divisor_in;
            DivZero     <= (Divisor_in == '0);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = '0;
      accept    = 1'b0;
      Load_ctrl = 1'b0;
      W_ctrl    = 1'b0;
      SRL_ctrl  = 1'b0;
      Ready     = 1'b0;
      Busy      = 1'b0;
      case (state)
         S_IDLE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            Load_ctrl = 1'b1;
            Busy      = 1'b1;
            state_nxt = DivZero ? S_DONE : S_ITER;
         end
         S_ITER: begin
            W_ctrl = 1'b1;
            Busy   = 1'b1;
            if (Count == LAST_ITER) state_nxt = S_SHIFT;
            else                    count_nxt = Count + CNT_W'(1);
         end
         S_SHIFT: begin
            SRL_ctrl  = 1'b1;
            Busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            Ready = 1'b1;
            if (Start) begin
               accept    = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Extra top bit captures the borrow: set when Remainder_hi < divisor_reg.
   assign diff       = {1'b0, Remainder_hi} - {1'b0, divisor_reg};
   assign ALU_Result = diff[WIDTH-1:0];
   assign ALU_Carry  = diff[WIDTH];

endmodule
